// File: rtl/crc_byte_feeder.sv
// Byte FIFO feeding the CRC32 engine: accepts 1/2/4-byte bus writes, emits bytes FWFT.
// Optional MSB-first storage of multi-byte writes is enabled by defining CRC_FEEDER_BSWAP_EN.
module crc_byte_feeder #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [1:0]    wr_size,
  input  logic [31:0]   wr_data,
`ifdef CRC_FEEDER_BSWAP_EN
  input  logic          bswap,
`endif
  output logic          wr_room,
  output logic          byte_valid,
  output logic [7:0]    byte_data,
  input  logic          byte_ready,
  input  logic          flush,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [31:0]   byte_count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   byte_count_q, byte_count_d;

  logic [AW:0]   push_n;
  logic [AW:0]   free_w;
  logic          accept;
  logic          pop;
  logic [7:0]    lane [4];

  always_comb begin
    unique case (wr_size)
      2'b00:   push_n = (AW+1)'(1);
      2'b01:   push_n = (AW+1)'(2);
      2'b10:   push_n = (AW+1)'(4);
      default: push_n = '0;
    endcase
  end

  // Room is judged on the registered level only; a same-cycle pop never makes room.
  assign free_w = (AW+1)'(DEPTH) - level_q;
  assign accept = wr_en && (push_n != '0) && (free_w >= push_n);
  assign pop    = (level_q != '0) && byte_ready;

  always_comb begin
    lane[0] = wr_data[7:0];
    lane[1] = wr_data[15:8];
    lane[2] = wr_data[23:16];
    lane[3] = wr_data[31:24];
`ifdef CRC_FEEDER_BSWAP_EN
    if (bswap && wr_size == 2'b10) begin
      lane[0] = wr_data[31:24];
      lane[1] = wr_data[23:16];
      lane[2] = wr_data[15:8];
      lane[3] = wr_data[7:0];
    end else if (bswap && wr_size == 2'b01) begin
      lane[0] = wr_data[15:8];
      lane[1] = wr_data[7:0];
    end
`endif
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    byte_count_d = byte_count_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + push_n[AW-1:0];
    end else if (wr_en && push_n != '0) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + AW'(1);
      byte_count_d = byte_count_q + 32'd1;
    end
    level_d = level_q + (accept ? push_n : '0) - (pop ? (AW+1)'(1) : '0);
  end

  // NOTE: the storage array has no reset; pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush && accept) begin
      for (int i = 0; i < 4; i++) begin
        if ((AW+1)'(i) < push_n) mem_q[wr_ptr_q + AW'(i)] <= lane[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign byte_valid = (level_q != '0);
  assign byte_data  = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;
  assign wr_room    = (free_w >= (AW+1)'(4));

endmodule

// File: tb/tb_crc_byte_feeder.sv
// Scoreboard bench for crc_byte_feeder: a byte queue models the FIFO and a negedge
// monitor compares level, status and every popped byte against it.
module tb_crc_byte_feeder;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_size = 2'b11;
  logic [31:0] wr_data = '0;
  logic        bswap_r = 1'b0;
  logic        wr_room;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  level;
  logic        overflow;
  logic [31:0] byte_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q [$];
  int          cur_level = 0;
  logic        ovf_m = 1'b0;
  logic        cur_ovf = 1'b0;
  logic [31:0] cnt_m = '0;
  logic        mon_on = 1'b0;

  crc_byte_feeder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_size    (wr_size),
    .wr_data    (wr_data),
`ifdef CRC_FEEDER_BSWAP_EN
    .bswap      (bswap_r),
`endif
    .wr_room    (wr_room),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .flush      (flush),
    .level      (level),
    .overflow   (overflow),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // Monitor: registered state is checked against the model mid-cycle, pops consume the queue.
  always @(negedge clk) begin
    if (mon_on && !rst && !flush) begin
      checks++;
      if (level !== 4'(cur_level) || byte_valid !== (cur_level != 0)) begin
        errors++;
        $display("FAIL mon_level: level=%0d valid=%b required level=%0d", level, byte_valid, cur_level);
      end
      checks++;
      if (overflow !== cur_ovf || byte_count !== cnt_m || wr_room !== (DEPTH - cur_level >= 4)) begin
        errors++;
        $display("FAIL mon_status: ovf=%b cnt=%0d room=%b required ovf=%b cnt=%0d room=%b",
                 overflow, byte_count, wr_room, cur_ovf, cnt_m, (DEPTH - cur_level >= 4));
      end
      if (byte_valid && byte_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_pop: got byte %h, required none", byte_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (byte_data !== e) begin
            errors++;
            $display("FAIL mon_pop: byte %h required %h", byte_data, e);
          end
        end
        cnt_m = cnt_m + 32'd1;
      end
    end
  end

  // One clock cycle of stimulus; the model decides acceptance from the level at cycle start.
  task automatic drive(input logic en, input logic [1:0] sz, input logic [31:0] d, input logic rdy);
    int n;
    cur_level  = exp_q.size();
    cur_ovf    = ovf_m;
    wr_en      = en;
    wr_size    = sz;
    wr_data    = d;
    byte_ready = rdy;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    if (en && n != 0 && !rst && !flush) begin
      if (DEPTH - exp_q.size() >= n) begin
        for (int i = 0; i < n; i++) begin
          if (bswap_r && n > 1) exp_q.push_back(d[8*(n-1-i) +: 8]);
          else                  exp_q.push_back(d[8*i +: 8]);
        end
      end else begin
        ovf_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rst || flush) begin
      exp_q.delete();
      ovf_m = 1'b0;
      cnt_m = '0;
    end
    wr_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    drive(1'b0, 2'b11, 32'h0, 1'b0);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'b11, 32'h0, 1'b0);
    drive(1'b0, 2'b11, 32'h0, 1'b0);
    rst = 1'b0;
    checks++;
    if (level !== 4'd0 || byte_valid !== 1'b0 || overflow !== 1'b0 || byte_count !== 32'd0) begin
      errors++;
      $display("FAIL reset: level=%0d valid=%b ovf=%b cnt=%0d required 0 0 0 0",
               level, byte_valid, overflow, byte_count);
    end
    mon_on = 1'b1;
  endtask

  task automatic test_basic();
    drive(1'b1, 2'b10, 32'h44332211, 1'b1);
    checks++;
    if (byte_valid !== 1'b1 || byte_data !== 8'h11) begin
      errors++;
      $display("FAIL basic_first: valid=%b data=%h required 1 11", byte_valid, byte_data);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b11, 32'h0, 1'b1);
    checks++;
    if (byte_valid !== 1'b0 || byte_count !== 32'd4) begin
      errors++;
      $display("FAIL basic_end: valid=%b cnt=%0d required 0 4", byte_valid, byte_count);
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 2'b10, 32'hDDCCBBAA, 1'b0);
    drive(1'b1, 2'b10, 32'hDDCCBBAA, 1'b0);
    checks++;
    if (level !== 4'd8 || wr_room !== 1'b0) begin
      errors++;
      $display("FAIL full: level=%0d room=%b required 8 0", level, wr_room);
    end
    drive(1'b1, 2'b00, 32'h55, 1'b0);
    checks++;
    if (overflow !== 1'b1 || level !== 4'd8) begin
      errors++;
      $display("FAIL reject8: ovf=%b level=%0d required 1 8", overflow, level);
    end
    drive(1'b1, 2'b11, 32'h12345678, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 2'b11, 32'h0, 1'b1);
    checks++;
    if (byte_valid !== 1'b0 || byte_count !== 32'd12) begin
      errors++;
      $display("FAIL drain8: valid=%b cnt=%0d required 0 12", byte_valid, byte_count);
    end
  endtask

  task automatic test_no_room_from_pop();
    do_flush();
    drive(1'b1, 2'b10, 32'h0D0C0B0A, 1'b0);
    drive(1'b1, 2'b10, 32'h1D1C1B1A, 1'b0);
    drive(1'b0, 2'b11, 32'h0, 1'b1);
    drive(1'b1, 2'b01, 32'h00006677, 1'b1);
    checks++;
    if (overflow !== 1'b1 || level !== 4'd6) begin
      errors++;
      $display("FAIL reject16: ovf=%b level=%0d required 1 6", overflow, level);
    end
    drive(1'b1, 2'b01, 32'h00006677, 1'b1);
    checks++;
    if (level !== 4'd7) begin
      errors++;
      $display("FAIL accept16: level=%0d required 7", level);
    end
    for (int i = 0; i < 7; i++) drive(1'b0, 2'b11, 32'h0, 1'b1);
  endtask

  task automatic test_wrap();
    logic [7:0] nxt;
    do_flush();
    nxt = 8'h00;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'b10, 32'h03020100 + 32'h04040404 * k, 1'b0);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (byte_data !== nxt) begin
          errors++;
          $display("FAIL wrap_seq: byte %h required %h", byte_data, nxt);
        end
        nxt = nxt + 8'h01;
        drive(1'b0, 2'b11, 32'h0, 1'b1);
      end
    end
    checks++;
    if (byte_count !== 32'd20 || byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: cnt=%0d valid=%b required 20 0", byte_count, byte_valid);
    end
  endtask

  task automatic test_flush_rst();
    drive(1'b1, 2'b10, 32'hA3A2A1A0, 1'b0);
    drive(1'b1, 2'b00, 32'h000000A4, 1'b0);
    drive(1'b1, 2'b10, 32'hEEEEEEEE, 1'b0);
    flush = 1'b1;
    drive(1'b1, 2'b10, 32'hB3B2B1B0, 1'b1);
    flush = 1'b0;
    checks++;
    if (level !== 4'd0 || byte_valid !== 1'b0 || overflow !== 1'b0 || byte_count !== 32'd0) begin
      errors++;
      $display("FAIL flush: level=%0d valid=%b ovf=%b cnt=%0d required 0 0 0 0",
               level, byte_valid, overflow, byte_count);
    end
    drive(1'b1, 2'b10, 32'hC3C2C1C0, 1'b1);
    drive(1'b0, 2'b11, 32'h0, 1'b1);
    rst = 1'b1;
    drive(1'b1, 2'b00, 32'h77, 1'b1);
    rst = 1'b0;
    checks++;
    if (level !== 4'd0 || byte_valid !== 1'b0 || overflow !== 1'b0 || byte_count !== 32'd0 || wr_room !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: level=%0d valid=%b ovf=%b cnt=%0d room=%b required 0 0 0 0 1",
               level, byte_valid, overflow, byte_count, wr_room);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) drive(1'b1, 2'b00, 32'(8'h30 + i), 1'b1);
    checks++;
    if (level !== 4'd1 || byte_data !== 8'h39 || byte_count !== 32'd9) begin
      errors++;
      $display("FAIL b2b: level=%0d data=%h cnt=%0d required 1 39 9", level, byte_data, byte_count);
    end
    drive(1'b0, 2'b11, 32'h0, 1'b1);
  endtask

  task automatic test_bswap();
`ifdef CRC_FEEDER_BSWAP_EN
    bswap_r = 1'b1;
    drive(1'b1, 2'b10, 32'h44332211, 1'b0);
    checks++;
    if (byte_data !== 8'h44) begin
      errors++;
      $display("FAIL bswap32: head %h required 44", byte_data);
    end
    drive(1'b1, 2'b00, 32'h00000099, 1'b0);
    drive(1'b1, 2'b01, 32'h0000BBAA, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 2'b11, 32'h0, 1'b1);
    bswap_r = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_no_room_from_pop();
    test_wrap();
    test_flush_rst();
    test_back_to_back();
    test_bswap();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d bytes never popped, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_byte_feeder.md
Name: crc_byte_feeder

Overview:
- Upstream stage of the CRC32 peripheral.
- Accepts 8/16/32-bit register writes from the TinyQV bus side and buffers them as bytes in a circular FIFO.
- Presents the bytes one at a time, LSB-first, to the CRC engine over a first-word-fall-through valid/ready handshake.
- Also keeps a running count of bytes delivered and sticky overflow status, both readable by software.

Parameters:
- DEPTH, 8, FIFO capacity in bytes; power of two, at least 4.
- AW, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous reset, active-high.
- wr_en, input, 1: write strobe, one cycle per bus write.
- wr_size, input, 2: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = no write (same encoding as data_write_n).
- wr_data, input, 32: write data; bytes taken from bit 0 upward.
- wr_room, output, 1: high when at least 4 bytes are free.
- byte_valid, output, 1: head byte available.
- byte_data, output, 8: head byte (FWFT).
- byte_ready, input, 1: consumer accepts the head byte this cycle.
- flush, input, 1: discard contents, clear counter and status.
- level, output, AW+1: bytes currently stored, 0..DEPTH.
- overflow, output, 1: sticky, set when a write was rejected.
- byte_count, output, 32: total bytes popped since reset/flush; wraps modulo 2^32.

Behaviour:
- Reset (rst high at posedge): all pointers 0, level = 0, byte_valid = 0, overflow = 0, byte_count = 0. Memory contents are don't-care.
- byte_data is undefined while byte_valid = 0.
- Push size N is 1, 2 or 4, decoded from wr_size. If wr_en = 1 and wr_size = 11, nothing happens and overflow is not set.
- Accept rule: a write is accepted only if (DEPTH − level) ≥ N, using the level registered at the start of the cycle.
  - A pop in the same cycle does not create room for that write.
  - Accepted: bytes wr_data[7:0], [15:8], … are written at wr_ptr, wr_ptr+1, … (mod DEPTH). wr_ptr advances by N.
  - Rejected: no bytes are written (never a partial write), pointers are unchanged, overflow is set to 1.
- Pop: when byte_valid and byte_ready are both high, rd_ptr advances by 1 and byte_count increments by 1. byte_ready with byte_valid = 0 is ignored.
- byte_valid = (level ≠ 0), driven from registered state. byte_data = mem[rd_ptr] combinationally.
  - Latency: a byte written in cycle T is visible at the outputs in cycle T+1.
- Simultaneous accepted push and pop: level_next = level + N − 1.
- Pointers wrap modulo DEPTH. level never exceeds DEPTH and never underflows.
- wr_room = (DEPTH − level) ≥ 4; purely informational, not a gating signal.
- flush has priority over push and pop in the same cycle. It sets pointers = 0, level = 0, overflow = 0 and byte_count = 0; the write and the pop in that cycle are dropped.
- rst has priority over flush. Reset asserted mid-stream empties the FIFO the next cycle regardless of the handshake.
- State machine: none beyond the pointer/level counters. The block is fully pipelined and can push and pop in every cycle.

Optional Feature:
- Macro CRC_FEEDER_BSWAP_EN.
- When defined: an extra input port bswap (1 bit) exists. When bswap = 1, multi-byte writes are stored MSB-first:
  - 32-bit: [31:24], [23:16], [15:8], [7:0].
  - 16-bit: [15:8], [7:0].
  - 8-bit writes are unaffected.
- When undefined: the port is absent and ordering is always LSB-first.

Test Plan:
- After reset, 32-bit write 0x44332211 (wr_size = 10), byte_ready = 1 continuously → byte_data reads 0x11, 0x22, 0x33, 0x44 on consecutive cycles starting 1 cycle after the write; then byte_valid = 0 and byte_count = 4.
- With byte_ready = 0, write 0xDDCCBBAA twice at 32 bits → level = 8, wr_room = 0. A third write of 8 bits, 0x55, is rejected: overflow = 1, level stays 8, and the subsequent drain yields AA BB CC DD AA BB CC DD only.
- At level = 7 with byte_ready = 1, write 16-bit 0x6677 → rejected (1 free < 2), overflow = 1, level = 6 after the cycle. Repeat at level = 6 → accepted and level stays 7 (6 + 2 − 1), with 0x77 enqueued before 0x66.
- Wrap-around: run 5 rounds of a 32-bit write followed by 4 pops, with data 0x03020100 + 0x04040404·k → output is the sequence 0x00..0x13 in order, pointers wrap cleanly, byte_count = 20.
- flush asserted at level 5 in the same cycle as a 32-bit write and byte_ready = 1 → next cycle level = 0, byte_valid = 0, overflow = 0, byte_count = 0, and the write is lost. Separately, rst asserted mid-drain → all outputs at reset values the next cycle.
- With CRC_FEEDER_BSWAP_EN defined and bswap = 1, write 32-bit 0x44332211 → output 0x44, 0x33, 0x22, 0x11. Then an 8-bit write of 0x99 → output 0x99.
